// File: rtl/buck_mphase_pwm_ctrl.sv
// buck_mphase_pwm_ctrl: N-phase interleaved PWM controller for a buck stage.
// One master counter sets the period. Each phase compares a phase-shifted copy
// of it against the effective duty. Dead time is inserted per phase on every
// turn-on edge, and the duty ramps up slowly (soft start) after enable.
// Duty commands are double-buffered and take effect on the period boundary.
// Optional over-current protection is compiled in with `define BUCK_PWM_OCP_EN
// (adds the oc_flag input, the OCP_MAX parameter and the FAULT state).
`timescale 1ns/1ps

module buck_mphase_pwm_ctrl #(
  parameter int NPH    = 4,
  parameter int CW     = 8,
  parameter int DTW    = 4,
  parameter int DMAX   = 240,
  parameter int SS_DIV = 4
`ifdef BUCK_PWM_OCP_EN
  ,
  parameter int OCP_MAX = 3
`endif
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  input  logic [CW-1:0]  duty_cmd,
  input  logic           duty_vld,
  input  logic [DTW-1:0] dead_t,
`ifdef BUCK_PWM_OCP_EN
  input  logic           oc_flag,
`endif
  output logic [NPH-1:0] hs_on,
  output logic [NPH-1:0] ls_on,
  output logic           ss_done,
  output logic           period_tick,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOFT  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0]  DMAX_C  = CW'(DMAX);
  localparam int             PH_STEP = (1 << CW) / NPH;
  localparam int             SSW     = $clog2(SS_DIV + 1);
  localparam logic [DTW:0]   AGE_MAX = {1'b0, {DTW{1'b1}}};

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            first_reg;
  logic            ss_done_reg;
  logic [SSW-1:0]  ss_cnt_reg;
  logic [CW-1:0]   shadow_reg;
  logic [CW-1:0]   d_act_reg;
  logic [CW-1:0]   d_eff_reg;
  logic [DTW-1:0]  dt_reg;

  logic            active;
  logic            gate_en;
  logic            wrap;
  logic [CW-1:0]   cmd_clamped;
  logic [CW-1:0]   d_act_nx;
  logic [CW-1:0]   d_eff;
  logic            ss_step;
  logic [CW:0]     ss_cand;
  logic            ramp_done;
  logic            hs_block;
  logic            fault_trip;

  // Counting states; gates are only driven while counting and still enabled.
  assign active  = (state_reg == SOFT) || (state_reg == RUN);
  assign gate_en = active && en;
  // Last cycle of a period: shadow transfer, dead-time sample, ramp step.
  assign wrap    = gate_en && (cnt_reg == CNT_MAX);

  assign cmd_clamped = (duty_cmd > DMAX_C) ? DMAX_C : duty_cmd;
  // A load coinciding with the transfer wins over the old shadow content.
  assign d_act_nx    = duty_vld ? cmd_clamped : shadow_reg;
  assign d_eff       = (state_reg == RUN) ? d_act_reg : d_eff_reg;

  // Soft start advances one LSB every SS_DIV periods; it ends as soon as the
  // ramp reaches the duty that will be active in the next period.
  assign ss_step   = (ss_cnt_reg == SSW'(SS_DIV - 1));
  assign ss_cand   = {1'b0, d_eff_reg} + {{CW{1'b0}}, ss_step};
  assign ramp_done = (ss_cand >= {1'b0, d_act_nx});

  assign period_tick = active && (cnt_reg == '0) && !first_reg;
  assign state       = state_reg;
  assign ss_done     = ss_done_reg;

`ifdef BUCK_PWM_OCP_EN
  localparam int OW = $clog2(OCP_MAX + 1);
  logic          oc_hit_reg;
  logic [OW-1:0] oc_per_reg;
  logic          oc_now;

  assign oc_now     = oc_flag || oc_hit_reg;
  assign hs_block   = oc_now;
  assign fault_trip = wrap && oc_now && (oc_per_reg == OW'(OCP_MAX - 1));

  // Remember an over-current event for the rest of the period and count
  // consecutive periods that contained one.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      oc_hit_reg <= 1'b0;
      oc_per_reg <= '0;
    end else if (!gate_en) begin
      oc_hit_reg <= 1'b0;
      oc_per_reg <= '0;
    end else if (wrap) begin
      oc_hit_reg <= 1'b0;
      oc_per_reg <= oc_now ? oc_per_reg + 1'b1 : '0;
    end else if (oc_flag) begin
      oc_hit_reg <= 1'b1;
    end
  end
`else
  assign hs_block   = 1'b0;
  assign fault_trip = 1'b0;
`endif

  // Controller FSM with master counter, soft-start ramp and status outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      first_reg   <= 1'b0;
      ss_done_reg <= 1'b0;
      ss_cnt_reg  <= '0;
      d_eff_reg   <= '0;
    end else if (!en) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      first_reg   <= 1'b0;
      ss_done_reg <= 1'b0;
      ss_cnt_reg  <= '0;
      d_eff_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= SOFT;
          cnt_reg   <= '0;
          first_reg <= 1'b1;
        end
        SOFT, RUN: begin
          cnt_reg   <= cnt_reg + 1'b1;
          first_reg <= 1'b0;
          if (wrap) begin
            if (fault_trip) begin
              state_reg <= FAULT;
            end else if (state_reg == SOFT) begin
              ss_cnt_reg <= ss_step ? '0 : ss_cnt_reg + 1'b1;
              if (ramp_done) begin
                d_eff_reg   <= d_act_nx;
                state_reg   <= RUN;
                ss_done_reg <= 1'b1;
              end else begin
                d_eff_reg <= ss_cand[CW-1:0];
              end
            end
          end
        end
        default: begin
          // FAULT: counter frozen, left only through en=0 or reset.
          state_reg <= FAULT;
        end
      endcase
    end
  end

  // Duty double buffer and per-period dead-time sample.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shadow_reg <= '0;
      d_act_reg  <= '0;
      dt_reg     <= '0;
    end else begin
      if (duty_vld)
        shadow_reg <= cmd_clamped;
      if (wrap)
        d_act_reg <= d_act_nx;
      if ((state_reg == IDLE) || wrap)
        dt_reg <= dead_t;
    end
  end

  // Per-phase comparator and dead-time gate. A switch may turn on only once
  // its raw command has been stable for more than dead_t cycles, so a raw
  // window shorter than or equal to the dead time produces no pulse at all.
  for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
    logic [CW-1:0]  pc;
    logic           hs_raw;
    logic           raw_prev_reg;
    logic [DTW-1:0] age_reg;
    logic [DTW:0]   run_len;
    logic           dt_ok;
    logic           hs_q;
    logic           ls_q;

    assign pc      = cnt_reg + CW'(gi * PH_STEP);
    assign hs_raw  = (pc < d_eff) && !hs_block;
    assign run_len = (hs_raw == raw_prev_reg) ? ({1'b0, age_reg} + (DTW+1)'(1))
                                              : (DTW+1)'(1);
    assign dt_ok   = (run_len > {1'b0, dt_reg});

    // Track raw-command stability and register the gated switch enables.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        raw_prev_reg <= 1'b0;
        age_reg      <= '0;
        hs_q         <= 1'b0;
        ls_q         <= 1'b0;
      end else if (!gate_en) begin
        raw_prev_reg <= 1'b0;
        age_reg      <= '0;
        hs_q         <= 1'b0;
        ls_q         <= 1'b0;
      end else begin
        raw_prev_reg <= hs_raw;
        age_reg      <= (run_len > AGE_MAX) ? AGE_MAX[DTW-1:0] : run_len[DTW-1:0];
        hs_q         <= hs_raw && dt_ok;
        ls_q         <= !hs_raw && dt_ok;
      end
    end

    assign hs_on[gi] = hs_q;
    assign ls_on[gi] = ls_q;
  end

endmodule

// File: doc/buck_mphase_pwm_ctrl.md
Name: buck_mphase_pwm_ctrl

Overview:
- Digital N-phase interleaved PWM controller. Successor to the single-phase sawtooth-comparator buck drive.
- Generates high-side/low-side gate enables per phase, with dead-time insertion and a soft-start ramp.
- Duty updates are double-buffered.
- Sits between the loop compensator (duty command source) and the per-phase power-stage models of the buck testbench.

Parameters:
- NPH, 4, number of interleaved phases (1..8, power of two)
- CW, 8, PWM counter width; period = 2^CW clk cycles
- DTW, 4, dead-time field width
- DMAX, 240, max effective duty in counts; duty_cmd is clamped to this
- SS_DIV, 4, PWM periods per +1 LSB soft-start step

Ports:
- clk  in  1  controller clock
- rstb  in  1  asynchronous active-low reset
- en  in  1  converter enable
- duty_cmd  in  CW  commanded duty in counts
- duty_vld  in  1  loads duty_cmd into the shadow register
- dead_t  in  DTW  dead time in clk cycles; sampled at period start
- hs_on  out  NPH  high-side enable per phase
- ls_on  out  NPH  low-side enable per phase
- ss_done  out  1  high once the soft-start ramp has completed
- period_tick  out  1  one-cycle pulse when the master counter wraps to 0
- state  out  2  FSM state (IDLE=0, SOFT=1, RUN=2, FAULT=3)

Behaviour:
- Reset (rstb low, asynchronous): all outputs and registers are 0; state=IDLE.
- Master counter cnt:
  - Increments every clk while state≠IDLE/FAULT; wraps 2^CW-1→0.
  - period_tick=1 in the cycle cnt==0, except the first cycle after leaving IDLE.
- Phase k counter: pc_k = (cnt + k·2^CW/NPH) mod 2^CW, truncated to CW bits.
- Shadow duty register:
  - duty_vld=1 loads min(duty_cmd, DMAX) into the shadow register.
  - Shadow transfers to active duty d_act only in the cycle cnt==2^CW-1, so it takes effect at the next period.
  - If duty_vld coincides with the transfer cycle, the new value is the one transferred.
- Effective duty d_eff:
  - SOFT: starts at 0 and increments by 1 every SS_DIV period_ticks. When d_eff ≥ d_act, d_eff=d_act, state→RUN, ss_done=1.
  - RUN: d_eff=d_act.
- Raw per-phase commands: hs_raw_k = (pc_k < d_eff); ls_raw_k = ~hs_raw_k.
- Dead time, per phase:
  - A rising edge on either raw command holds that switch off for dead_t cycles after the opposite switch turns off.
  - Both hs_on_k and ls_on_k are never 1 together.
  - dead_t=0: hs_on_k/ls_on_k follow the raw commands registered one cycle late.
  - Output latency from pc_k change to gate change = 1 + dead_t cycles on on-edges, 1 cycle on off-edges.
- Boundary duty values:
  - d_eff=0: hs_on_k stays 0; ls_on_k stays 1 after the initial dead time.
  - d_eff=DMAX=2^CW-1 with dead_t=0: a 1-cycle LS pulse per period.
  - If dead_t ≥ the LS on-window, LS stays 0 that period (no glitch).
- FSM:
  - IDLE→SOFT on en=1.
  - SOFT→RUN when the ramp completes.
  - Any state→IDLE on en=0 within 1 cycle. All gate outputs go 0, cnt=0, d_eff=0, ss_done=0.
  - Re-enabling always re-runs soft start.
  - FAULT exists only with the optional feature; otherwise it is unreachable.
- Reset mid-period: immediate return to the reset state; no partial pulses.

Optional Feature:
- Macro BUCK_PWM_OCP_EN.
- When defined:
  - Adds input oc_flag (1 bit) and parameter OCP_MAX (default 3).
  - oc_flag=1 forces all hs_on to 0 within 1 cycle for the rest of the current period; ls_on follows normal dead-time rules.
  - A counter tracks consecutive periods containing at least one oc_flag. It clears on a period with no oc_flag.
  - Reaching OCP_MAX → state=FAULT: all gates 0, cnt frozen. Exit is only via en=0 (→IDLE) or reset.
- When undefined: no oc_flag port; FAULT is never entered.

Test Plan:
- Reset/IDLE: rstb=0 mid-run with en=1 and RUN at d=128 → all outputs 0 in the same cycle; after release with en=1 the FSM enters SOFT and ss_done=0.
- Soft start: NPH=4, CW=8, SS_DIV=4, duty_cmd=16 → d_eff steps 0,1,…,16 every 4 periods; ss_done rises after 64 period_ticks; state=RUN.
- Interleave: RUN, d=64, dead_t=0 → phase k hs_on rises at cnt=(256-64k) mod 256; each phase is high for 64 cycles per 256-cycle period.
- Dead time: d=128, dead_t=5 → in every phase, the gap between hs_on fall and ls_on rise (and vice versa) is exactly 5 cycles; never both 1.
- Double buffering and clamp: duty_vld with 250 at cnt=100 → hs width unchanged until the next period, then 240 (clamped); duty_vld at cnt=255 takes effect at the next period.
- OCP (BUCK_PWM_OCP_EN): oc_flag pulses in 3 consecutive periods → hs_on truncated each period, then state=FAULT and all gates 0; en=0 → IDLE.
